// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered MIPS32 decode stage with forwarding, load-use stall and ID/EX register
module id_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter bit FWD_EN    = 1'b1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          inst_i,
  input  logic [DATA_W-1:0]    reg1_data_i,
  input  logic [DATA_W-1:0]    reg2_data_i,
  input  logic                 ex_wreg_i,
  input  logic [4:0]           ex_wd_i,
  input  logic [DATA_W-1:0]    ex_wdata_i,
  input  logic                 ex_is_load_i,
  input  logic                 mem_wreg_i,
  input  logic [4:0]           mem_wd_i,
  input  logic [DATA_W-1:0]    mem_wdata_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 reg1_read_o,
  output logic                 reg2_read_o,
  output logic [4:0]           reg1_addr_o,
  output logic [4:0]           reg2_addr_o,
  output logic                 stallreq_o,
  output logic [7:0]           aluop_o,
  output logic [2:0]           alusel_o,
  output logic [DATA_W-1:0]    reg1_o,
  output logic [DATA_W-1:0]    reg2_o,
  output logic [4:0]           wd_o,
  output logic                 wreg_o,
  output logic [31:0]          pc_o,
  output logic                 inst_invalid_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [4:0]        dec_wd;
  logic              dec_wreg;
  logic              dec_valid;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign op          = inst_i[31:26];
  assign funct       = inst_i[5:0];
  assign reg1_addr_o = inst_i[25:21];
  assign reg2_addr_o = inst_i[20:16];

  // Operand select: immediate when the port is unused, $0 reads as zero, then EX > MEM > regfile.
  // A load in EX has no result yet, so it never forwards; the stall logic covers that case.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic              rd_en,
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] imm_v,
    input logic              ex_wreg,
    input logic [4:0]        ex_wd,
    input logic              ex_load,
    input logic [DATA_W-1:0] ex_data,
    input logic              mem_wreg,
    input logic [4:0]        mem_wd,
    input logic [DATA_W-1:0] mem_data
  );
    if (!rd_en)
      return imm_v;
    else if (addr == 5'd0)
      return '0;
    else if (FWD_EN && ex_wreg && (ex_wd == addr) && !ex_load)
      return ex_data;
    else if (FWD_EN && mem_wreg && (mem_wd == addr))
      return mem_data;
    else
      return rf_data;
  endfunction

  // Instruction decode of the logic/shift/LUI subset
  always_comb begin
    dec_aluop   = EXE_NOP_OP;
    dec_alusel  = EXE_RES_NOP;
    dec_wd      = inst_i[15:11];
    dec_wreg    = 1'b0;
    dec_valid   = 1'b0;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    imm         = '0;
    if (inst_i == 32'h0) begin
      dec_valid = 1'b1;
    end else begin
      case (op)
        OP_SPECIAL: begin
          case (funct)
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              dec_valid   = 1'b1;
              dec_wreg    = 1'b1;
              dec_alusel  = EXE_RES_LOGIC;
              reg1_read_o = 1'b1;
              reg2_read_o = 1'b1;
              case (funct)
                FN_AND:  dec_aluop = EXE_AND_OP;
                FN_OR:   dec_aluop = EXE_OR_OP;
                FN_XOR:  dec_aluop = EXE_XOR_OP;
                default: dec_aluop = EXE_NOR_OP;
              endcase
            end
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
              dec_valid   = 1'b1;
              dec_wreg    = 1'b1;
              dec_alusel  = EXE_RES_SHIFT;
              reg2_read_o = 1'b1;
              // Variable shifts take the amount from rs; fixed shifts from the sa field
              reg1_read_o = funct[2];
              imm         = DATA_W'(inst_i[10:6]);
              case (funct[1:0])
                2'b00:   dec_aluop = EXE_SLL_OP;
                2'b10:   dec_aluop = EXE_SRL_OP;
                default: dec_aluop = EXE_SRA_OP;
              endcase
            end
            default: ;
          endcase
        end
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          dec_valid   = 1'b1;
          dec_wreg    = 1'b1;
          dec_wd      = inst_i[20:16];
          dec_alusel  = EXE_RES_LOGIC;
          reg1_read_o = 1'b1;
          imm         = DATA_W'(inst_i[15:0]);
          case (op)
            OP_ANDI: dec_aluop = EXE_AND_OP;
            OP_XORI: dec_aluop = EXE_XOR_OP;
            OP_LUI: begin
              dec_aluop = EXE_OR_OP;
              imm       = DATA_W'({inst_i[15:0], 16'h0000});
            end
            default: dec_aluop = EXE_OR_OP;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Operand resolution for both EX inputs
  always_comb begin
    op1 = pick_operand(reg1_read_o, reg1_addr_o, reg1_data_i, imm, ex_wreg_i, ex_wd_i,
                       ex_is_load_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
    op2 = pick_operand(reg2_read_o, reg2_addr_o, reg2_data_i, imm, ex_wreg_i, ex_wd_i,
                       ex_is_load_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  end

  // Load-use hazard: the loaded value is needed before it exists
  always_comb begin
    stallreq_o = rst && ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                 ((reg1_read_o && (ex_wd_i == reg1_addr_o)) ||
                  (reg2_read_o && (ex_wd_i == reg2_addr_o)));
  end

  // ID/EX register: flush beats stall, stall beats hazard bubble, otherwise load the decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluop_o        <= EXE_NOP_OP;
      alusel_o       <= EXE_RES_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= 5'd0;
      wreg_o         <= 1'b0;
      pc_o           <= 32'h0;
      inst_invalid_o <= 1'b0;
      err_cnt_o      <= '0;
    end else if (flush_i || (!stall_i && stallreq_o)) begin
      aluop_o        <= EXE_NOP_OP;
      alusel_o       <= EXE_RES_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= 5'd0;
      wreg_o         <= 1'b0;
      pc_o           <= pc_i;
      inst_invalid_o <= 1'b0;
    end else if (!stall_i) begin
      aluop_o        <= dec_aluop;
      alusel_o       <= dec_alusel;
      reg1_o         <= op1;
      reg2_o         <= op2;
      wd_o           <= dec_wd;
      wreg_o         <= dec_wreg;
      pc_o           <= pc_i;
      inst_invalid_o <= !dec_valid;
      if (!dec_valid && (err_cnt_o != '1))
        err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

endmodule
